// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and constants for the operand-forwarding / multi-cycle scoreboard slice.
package fwd_scoreboard_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned NUM_ARCH_REGS = 32;
    localparam int unsigned MC_DEPTH_MAX  = 8;
    localparam int unsigned REG_IDX_W     = 5;

    // One later pipeline stage offering its result for bypass
    typedef struct packed {
        logic [REG_IDX_W-1:0] addr;
        logic [XLEN-1:0]      data;
        logic                 valid;
        logic                 ready;
    } fwd_port_t;

endpackage

// File: rtl/mc_scoreboard.sv
// Busy bitmap, outstanding-op counter and sticky error flag for multi-cycle destinations.
module mc_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter  int unsigned MC_DEPTH = 2,
    localparam int unsigned PW       = $clog2(MC_DEPTH + 1)
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     issue_i,
    input  logic [REG_IDX_W-1:0]     issue_rd_i,
    input  logic                     done_i,
    input  logic [REG_IDX_W-1:0]     done_rd_i,
    output logic [NUM_ARCH_REGS-1:0] busy_o,
    output logic [PW-1:0]            pending_o,
    output logic                     err_o
);

    logic [NUM_ARCH_REGS-1:0] busy_q, busy_d;
    logic [PW-1:0]            pend_q, pend_d;
    logic                     err_q, err_d;
    logic                     done_ok;

    // A completion only counts if its destination was actually outstanding
    assign done_ok = done_i && busy_q[done_rd_i];

    always_comb begin
        busy_d = busy_q;
        pend_d = pend_q;
        err_d  = err_q;
        if (issue_i) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        if (done_ok) begin
            busy_d[done_rd_i] = 1'b0;
        end else if (done_i) begin
            err_d = 1'b1;
        end
        case ({issue_i, done_ok})
            2'b10:   pend_d = pend_q + PW'(1);
            2'b01:   pend_d = pend_q - PW'(1);
            default: pend_d = pend_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            busy_q <= '0;
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign busy_o    = busy_q;
    assign pending_o = pend_q;
    assign err_o     = err_q;

endmodule

// File: rtl/fwd_scoreboard.sv
// Decode-stage operand forwarding, hazard stall/flush generation and stall-cycle counter.
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter  int unsigned NUM_FWD  = 3,
    parameter  int unsigned MC_DEPTH = 2,
    localparam int unsigned SELW     = $clog2(NUM_FWD + 1),
    localparam int unsigned PW       = $clog2(MC_DEPTH + 1)
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [REG_IDX_W-1:0]        rs1D_idx_i,
    input  logic [REG_IDX_W-1:0]        rs2D_idx_i,
    input  logic [1:0]                  rs_used_i,
    input  logic [XLEN-1:0]             rs1D_data_i,
    input  logic [XLEN-1:0]             rs2D_data_i,
    input  logic [REG_IDX_W-1:0]        rdD_idx_i,
    input  logic                        rdD_wr_i,
    input  logic                        issue_mc_i,
    input  fwd_port_t [NUM_FWD-1:0]     fwd_port_i,
    input  logic                        mc_done_i,
    input  logic [REG_IDX_W-1:0]        mc_done_rd_i,
    input  logic                        branch_tkn_i,
    output logic [XLEN-1:0]             rs1_o,
    output logic [XLEN-1:0]             rs2_o,
    output logic [SELW-1:0]             fwd_sel1_o,
    output logic [SELW-1:0]             fwd_sel2_o,
    output logic                        stall_o,
    output logic                        pc_en_o,
    output logic                        flush_o,
    output logic [PW-1:0]               mc_pending_o,
    output logic [31:0]                 stall_cnt_o,
    output logic                        err_o
);

    logic [NUM_ARCH_REGS-1:0] busy;
    logic [REG_IDX_W-1:0]     src_idx [2];
    logic [XLEN-1:0]          src_rf  [2];
    logic [SELW-1:0]          sel     [2];
    logic [XLEN-1:0]          opnd    [2];
    logic [1:0]               src_stall;
    logic                     waw_stall, cap_stall, stall_raw, issue;
    logic [31:0]              stall_cnt_q, stall_cnt_d;

    assign src_idx[0] = rs1D_idx_i;
    assign src_idx[1] = rs2D_idx_i;
    assign src_rf[0]  = rs1D_data_i;
    assign src_rf[1]  = rs2D_data_i;

    // Youngest matching stage wins; x0 always reads as zero from the register file
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            logic found;
            found        = 1'b0;
            sel[s]       = '0;
            opnd[s]      = '0;
            src_stall[s] = 1'b0;
            if (src_idx[s] != '0) begin
                opnd[s] = src_rf[s];
                if (rs_used_i[s]) begin
                    for (int k = 0; k < int'(NUM_FWD); k++) begin
                        if (!found && fwd_port_i[k].valid && fwd_port_i[k].addr == src_idx[s]) begin
                            found        = 1'b1;
                            sel[s]       = SELW'(k + 1);
                            opnd[s]      = fwd_port_i[k].data;
                            src_stall[s] = !fwd_port_i[k].ready;
                        end
                    end
                    if (busy[src_idx[s]]) begin
                        src_stall[s] = 1'b1;
                    end
                end
            end
        end
    end

    assign waw_stall = issue_mc_i && rdD_wr_i && busy[rdD_idx_i];
    assign cap_stall = issue_mc_i && (mc_pending_o == PW'(MC_DEPTH));
    assign stall_raw = (|src_stall) || waw_stall || cap_stall;

    // A taken branch squashes decode, so it overrides any stall
    assign flush_o = branch_tkn_i;
    assign stall_o = stall_raw && !branch_tkn_i;
    assign pc_en_o = !stall_o;
    assign issue   = !stall_o && !branch_tkn_i && issue_mc_i && rdD_wr_i && (rdD_idx_i != '0);

    assign rs1_o      = opnd[0];
    assign rs2_o      = opnd[1];
    assign fwd_sel1_o = sel[0];
    assign fwd_sel2_o = sel[1];

    mc_scoreboard #(
        .MC_DEPTH (MC_DEPTH)
    ) u_mc_scoreboard (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .issue_i    (issue),
        .issue_rd_i (rdD_idx_i),
        .done_i     (mc_done_i),
        .done_rd_i  (mc_done_rd_i),
        .busy_o     (busy),
        .pending_o  (mc_pending_o),
        .err_o      (err_o)
    );

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed scenarios plus a randomized run against a behavioural model of fwd_scoreboard.
module tb_fwd_scoreboard;
    import fwd_scoreboard_pkg::*;

    localparam int unsigned NF   = 3;
    localparam int unsigned MD   = 2;
    localparam int unsigned SELW = 2;
    localparam int unsigned PW   = 2;

    logic                clk = 1'b0;
    logic                rstn;
    logic [4:0]          rs1, rs2, rd, done_rd;
    logic [1:0]          used;
    logic [XLEN-1:0]     rf1, rf2;
    logic                rd_wr, issue_mc, done, branch;
    fwd_port_t [NF-1:0]  fwd;
    logic [XLEN-1:0]     rs1_o, rs2_o;
    logic [SELW-1:0]     sel1_o, sel2_o;
    logic                stall_o, pc_en_o, flush_o, err_o;
    logic [PW-1:0]       pend_o;
    logic [31:0]         cnt_o;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit [31:0] mbusy;
    int        mpend;
    bit        merr;
    bit [31:0] mcnt;

    always #5 clk = ~clk;

    fwd_scoreboard #(.NUM_FWD(NF), .MC_DEPTH(MD)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .rs1D_idx_i   (rs1),
        .rs2D_idx_i   (rs2),
        .rs_used_i    (used),
        .rs1D_data_i  (rf1),
        .rs2D_data_i  (rf2),
        .rdD_idx_i    (rd),
        .rdD_wr_i     (rd_wr),
        .issue_mc_i   (issue_mc),
        .fwd_port_i   (fwd),
        .mc_done_i    (done),
        .mc_done_rd_i (done_rd),
        .branch_tkn_i (branch),
        .rs1_o        (rs1_o),
        .rs2_o        (rs2_o),
        .fwd_sel1_o   (sel1_o),
        .fwd_sel2_o   (sel2_o),
        .stall_o      (stall_o),
        .pc_en_o      (pc_en_o),
        .flush_o      (flush_o),
        .mc_pending_o (pend_o),
        .stall_cnt_o  (cnt_o),
        .err_o        (err_o)
    );

    task automatic idle();
        rs1 = '0; rs2 = '0; rd = '0; done_rd = '0; used = '0;
        rf1 = '0; rf2 = '0; rd_wr = 1'b0; issue_mc = 1'b0; done = 1'b0; branch = 1'b0;
        fwd = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rstn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // ---- reference model ----
    function automatic logic [SELW-1:0] ref_sel(input logic [4:0] idx, input logic u);
        if (idx == 5'd0 || !u) return '0;
        for (int k = 0; k < int'(NF); k++)
            if (fwd[k].valid && fwd[k].addr == idx) return SELW'(k + 1);
        return '0;
    endfunction

    function automatic logic [XLEN-1:0] ref_op(input logic [4:0] idx, input logic u, input logic [XLEN-1:0] rf);
        logic [SELW-1:0] s;
        s = ref_sel(idx, u);
        if (idx == 5'd0) return '0;
        if (s == '0) return rf;
        return fwd[int'(s) - 1].data;
    endfunction

    function automatic bit ref_src_stall(input logic [4:0] idx, input logic u);
        logic [SELW-1:0] s;
        if (!u || idx == 5'd0) return 1'b0;
        s = ref_sel(idx, u);
        if (s != '0 && !fwd[int'(s) - 1].ready) return 1'b1;
        return mbusy[idx];
    endfunction

    function automatic bit ref_stall();
        bit st;
        st = ref_src_stall(rs1, used[0]) || ref_src_stall(rs2, used[1])
           || (issue_mc && rd_wr && mbusy[rd]) || (issue_mc && mpend == int'(MD));
        return st && !branch;
    endfunction

    task automatic ref_commit();
        bit st, ok, iss;
        st  = ref_stall();
        ok  = done && mbusy[done_rd];
        iss = !st && !branch && issue_mc && rd_wr && rd != 5'd0;
        if (st && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 32'd1;
        if (done) begin
            if (ok) begin mbusy[done_rd] = 1'b0; mpend = mpend - 1; end
            else merr = 1'b1;
        end
        if (iss) begin mbusy[rd] = 1'b1; mpend = mpend + 1; end
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        idle();
        rstn = 1'b0;
        #3;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
        total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", flush_o); end
        total++; if (pc_en_o !== 1'b1) begin bad++; $display("FAIL reset_pc_en got=%b exp=1", pc_en_o); end
        total++; if (pend_o !== 2'd0) begin bad++; $display("FAIL reset_pending got=%0d exp=0", pend_o); end
        total++; if (cnt_o !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_o); end
        do_reset();
    endtask

    task automatic test_fwd_priority();
        do_reset();
        fwd[0] = '{addr: 5'd5, data: 32'hA, valid: 1'b1, ready: 1'b1};
        fwd[1] = '{addr: 5'd3, data: 32'hB, valid: 1'b1, ready: 1'b1};
        fwd[2] = '{addr: 5'd5, data: 32'hC, valid: 1'b1, ready: 1'b1};
        rs1 = 5'd5; rs2 = 5'd0; used = 2'b11; rf1 = 32'h1111; rf2 = 32'h2222;
        @(negedge clk);
        total++; if (sel1_o !== 2'd1) begin bad++; $display("FAIL prio_sel1 got=%0d exp=1", sel1_o); end
        total++; if (rs1_o !== 32'hA) begin bad++; $display("FAIL prio_rs1 got=%h exp=a", rs1_o); end
        total++; if (sel2_o !== 2'd0) begin bad++; $display("FAIL x0_sel2 got=%0d exp=0", sel2_o); end
        total++; if (rs2_o !== 32'h0) begin bad++; $display("FAIL x0_rs2 got=%h exp=0", rs2_o); end
        tick();
        fwd[0].valid = 1'b0; rs2 = 5'd5;
        @(negedge clk);
        total++; if (sel2_o !== 2'd3) begin bad++; $display("FAIL older_sel2 got=%0d exp=3", sel2_o); end
        total++; if (rs2_o !== 32'hC) begin bad++; $display("FAIL older_rs2 got=%h exp=c", rs2_o); end
        rs2 = 5'd6;
        #1;
        total++; if (rs2_o !== 32'h2222 || sel2_o !== 2'd0) begin bad++; $display("FAIL rf_rs2 got=%h/%0d exp=2222/0", rs2_o, sel2_o); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        fwd[0] = '{addr: 5'd7, data: 32'h77, valid: 1'b1, ready: 1'b0};
        rs2 = 5'd7; used = 2'b10;
        @(negedge clk);
        total++; if (stall_o !== 1'b1 || pc_en_o !== 1'b0) begin bad++; $display("FAIL lu_stall got=%b/%b exp=1/0", stall_o, pc_en_o); end
        tick();
        fwd[0].ready = 1'b1;
        @(negedge clk);
        total++; if (cnt_o !== 32'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=1", cnt_o); end
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL lu_release got=%b exp=0", stall_o); end
        total++; if (sel2_o !== 2'd1 || rs2_o !== 32'h77) begin bad++; $display("FAIL lu_sel2 got=%0d/%h exp=1/77", sel2_o, rs2_o); end
        tick();
    endtask

    task automatic test_mc_busy();
        do_reset();
        issue_mc = 1'b1; rd_wr = 1'b1; rd = 5'd9;
        @(negedge clk);
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL mc_issue_stall got=%b exp=0", stall_o); end
        tick();
        issue_mc = 1'b0; rd_wr = 1'b0; rs1 = 5'd9; used = 2'b01;
        @(negedge clk);
        total++; if (stall_o !== 1'b1 || pend_o !== 2'd1) begin bad++; $display("FAIL mc_dep got=%b/%0d exp=1/1", stall_o, pend_o); end
        tick();
        tick();
        done = 1'b1; done_rd = 5'd9;
        @(negedge clk);
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL mc_done_nobypass got=%b exp=1", stall_o); end
        tick();
        done = 1'b0;
        @(negedge clk);
        total++; if (stall_o !== 1'b0 || pend_o !== 2'd0) begin bad++; $display("FAIL mc_release got=%b/%0d exp=0/0", stall_o, pend_o); end
        total++; if (cnt_o !== 32'd3) begin bad++; $display("FAIL mc_cnt got=%0d exp=3", cnt_o); end
        tick();
    endtask

    task automatic test_capacity();
        do_reset();
        issue_mc = 1'b1; rd_wr = 1'b1; rd = 5'd1;
        tick();
        rd = 5'd2;
        @(negedge clk);
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL cap_second got=%b exp=0", stall_o); end
        tick();
        rd = 5'd3;
        @(negedge clk);
        total++; if (stall_o !== 1'b1 || pend_o !== 2'd2) begin bad++; $display("FAIL cap_full got=%b/%0d exp=1/2", stall_o, pend_o); end
        tick();
        done = 1'b1; done_rd = 5'd2;
        @(negedge clk);
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL cap_same_cycle got=%b exp=1", stall_o); end
        tick();
        done = 1'b0; rd = 5'd1;
        @(negedge clk);
        total++; if (stall_o !== 1'b1 || pend_o !== 2'd1) begin bad++; $display("FAIL waw got=%b/%0d exp=1/1", stall_o, pend_o); end
        tick();
        rd = 5'd3;
        @(negedge clk);
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL cap_free got=%b exp=0", stall_o); end
        tick();
        idle();
        @(negedge clk);
        total++; if (pend_o !== 2'd2) begin bad++; $display("FAIL cap_pending got=%0d exp=2", pend_o); end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        fwd[0] = '{addr: 5'd7, data: 32'h7, valid: 1'b1, ready: 1'b0};
        rs1 = 5'd7; used = 2'b01; issue_mc = 1'b1; rd_wr = 1'b1; rd = 5'd10; branch = 1'b1;
        @(negedge clk);
        total++; if (flush_o !== 1'b1 || stall_o !== 1'b0 || pc_en_o !== 1'b1) begin
            bad++; $display("FAIL flush_wins got=%b/%b/%b exp=1/0/1", flush_o, stall_o, pc_en_o); end
        tick();
        idle();
        rs1 = 5'd10; used = 2'b01;
        @(negedge clk);
        total++; if (stall_o !== 1'b0 || pend_o !== 2'd0 || cnt_o !== 32'd0) begin
            bad++; $display("FAIL flush_noissue got=%b/%0d/%0d exp=0/0/0", stall_o, pend_o, cnt_o); end
        tick();
    endtask

    task automatic test_err();
        do_reset();
        done = 1'b1; done_rd = 5'd4;
        tick();
        done = 1'b0;
        @(negedge clk);
        total++; if (err_o !== 1'b1 || pend_o !== 2'd0) begin bad++; $display("FAIL err_set got=%b/%0d exp=1/0", err_o, pend_o); end
        tick();
        tick();
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err_o); end
    endtask

    task automatic test_reset_mid();
        issue_mc = 1'b1; rd_wr = 1'b1; rd = 5'd9;
        tick();
        idle();
        rs1 = 5'd9; used = 2'b01;
        tick();
        @(negedge clk);
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL rm_pre got=%b exp=1", stall_o); end
        #1 rstn = 1'b0;
        #1;
        total++; if (stall_o !== 1'b0 || pc_en_o !== 1'b1 || pend_o !== 2'd0) begin
            bad++; $display("FAIL rm_state got=%b/%b/%0d exp=0/1/0", stall_o, pc_en_o, pend_o); end
        total++; if (cnt_o !== 32'd0 || err_o !== 1'b0) begin bad++; $display("FAIL rm_cnt_err got=%0d/%b exp=0/0", cnt_o, err_o); end
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int cand[$];
        do_reset();
        mbusy = '0; mpend = 0; merr = 1'b0; mcnt = '0;
        for (int n = 0; n < 400; n++) begin
            rs1  = 5'($urandom_range(0, 7));
            rs2  = 5'($urandom_range(0, 7));
            used = 2'($urandom);
            rf1  = $urandom;
            rf2  = $urandom;
            for (int k = 0; k < int'(NF); k++) begin
                fwd[k].addr  = 5'($urandom_range(0, 7));
                fwd[k].data  = $urandom;
                fwd[k].valid = 1'($urandom);
                fwd[k].ready = ($urandom % 4) != 0;
            end
            issue_mc = ($urandom % 3) == 0;
            rd_wr    = ($urandom % 4) != 0;
            rd       = 5'($urandom_range(0, 7));
            branch   = ($urandom % 8) == 0;
            cand.delete();
            for (int r = 1; r < 32; r++) if (mbusy[r]) cand.push_back(r);
            if (cand.size() > 0 && ($urandom % 3) == 0) begin
                done = 1'b1; done_rd = 5'(cand[$urandom % cand.size()]);
            end else begin
                done = 1'b0; done_rd = 5'($urandom);
            end
            @(negedge clk);
            total++; if (sel1_o !== ref_sel(rs1, used[0])) begin bad++; $display("FAIL rnd_sel1 n=%0d got=%0d exp=%0d", n, sel1_o, ref_sel(rs1, used[0])); end
            total++; if (sel2_o !== ref_sel(rs2, used[1])) begin bad++; $display("FAIL rnd_sel2 n=%0d got=%0d exp=%0d", n, sel2_o, ref_sel(rs2, used[1])); end
            total++; if (rs1_o !== ref_op(rs1, used[0], rf1)) begin bad++; $display("FAIL rnd_rs1 n=%0d got=%h exp=%h", n, rs1_o, ref_op(rs1, used[0], rf1)); end
            total++; if (rs2_o !== ref_op(rs2, used[1], rf2)) begin bad++; $display("FAIL rnd_rs2 n=%0d got=%h exp=%h", n, rs2_o, ref_op(rs2, used[1], rf2)); end
            total++; if (stall_o !== ref_stall()) begin bad++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall_o, ref_stall()); end
            total++; if (pc_en_o !== !ref_stall()) begin bad++; $display("FAIL rnd_pc_en n=%0d got=%b exp=%b", n, pc_en_o, !ref_stall()); end
            total++; if (flush_o !== branch) begin bad++; $display("FAIL rnd_flush n=%0d got=%b exp=%b", n, flush_o, branch); end
            total++; if (int'(pend_o) !== mpend) begin bad++; $display("FAIL rnd_pending n=%0d got=%0d exp=%0d", n, pend_o, mpend); end
            total++; if (cnt_o !== mcnt) begin bad++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, cnt_o, mcnt); end
            total++; if (err_o !== merr) begin bad++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, err_o, merr); end
            ref_commit();
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        rstn = 1'b1;
        #2;
        test_reset();
        test_fwd_priority();
        test_load_use();
        test_mc_busy();
        test_capacity();
        test_flush();
        test_random();
        test_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
